cdb_arbiter: RTL and testbench



---
 rtl/cdb_arbiter.sv | 93 +++++++++
 tb/tb_cdb_arbiter.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// Round-robin CDB writeback arbiter: grants up to CDB_WIDTH of N_REQ requesters per
// cycle in rotating priority order and registers the winners onto the broadcast ports.
module cdb_arbiter #(
  parameter int N_REQ     = 3,
  parameter int CDB_WIDTH = 2,
  parameter int ROB_IDX   = 5,
  parameter int PRF_IDX   = 6,
  parameter int ARF_IDX   = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic [N_REQ-1:0]     req_valid,
  output logic [N_REQ-1:0]     req_ready,
  input  logic [ROB_IDX-1:0]   req_rob_id   [N_REQ],
  input  logic [PRF_IDX-1:0]   req_rd_phy   [N_REQ],
  input  logic [ARF_IDX-1:0]   req_rd_arch  [N_REQ],
  input  logic [31:0]          req_rd_value [N_REQ],
  output logic [CDB_WIDTH-1:0] cdb_valid,
  output logic [ROB_IDX-1:0]   cdb_rob_id   [CDB_WIDTH],
  output logic [PRF_IDX-1:0]   cdb_rd_phy   [CDB_WIDTH],
  output logic [ARF_IDX-1:0]   cdb_rd_arch  [CDB_WIDTH],
  output logic [31:0]          cdb_rd_value [CDB_WIDTH]
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [PTR_W-1:0]     ptr;
  logic [PTR_W-1:0]     ptr_nxt;
  logic [PTR_W-1:0]     last_idx;
  logic [PTR_W-1:0]     idx;
  logic [PTR_W-1:0]     port_src [CDB_WIDTH];
  logic [CDB_WIDTH-1:0] port_grant;
  int                   cnt;
  int                   scan;

  // Scan from ptr with a true modulo-N_REQ wrap; the g-th winner drives port g.
  always_comb begin
    req_ready  = '0;
    port_grant = '0;
    cnt        = 0;
    scan       = 0;
    idx        = '0;
    last_idx   = ptr;
    for (int j = 0; j < CDB_WIDTH; j++) port_src[j] = '0;
    for (int k = 0; k < N_REQ; k++) begin
      scan = int'(ptr) + k;
      if (scan >= N_REQ) scan = scan - N_REQ;
      idx = PTR_W'(scan);
      if (!rst && !flush && req_valid[idx] && cnt < CDB_WIDTH) begin
        req_ready[idx] = 1'b1;
        for (int j = 0; j < CDB_WIDTH; j++) begin
          if (j == cnt) begin
            port_src[j]   = idx;
            port_grant[j] = 1'b1;
          end
        end
        cnt      = cnt + 1;
        last_idx = idx;
      end
    end
    ptr_nxt = (last_idx == PTR_W'(N_REQ - 1)) ? '0 : last_idx + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr       <= '0;
      cdb_valid <= '0;
      for (int j = 0; j < CDB_WIDTH; j++) begin
        cdb_rob_id[j]   <= '0;
        cdb_rd_phy[j]   <= '0;
        cdb_rd_arch[j]  <= '0;
        cdb_rd_value[j] <= '0;
      end
    end else if (flush) begin
      ptr       <= '0;
      cdb_valid <= '0;
    end else begin
      cdb_valid <= port_grant;
      if (port_grant[0]) ptr <= ptr_nxt;
      // Ungranted ports keep their last payload; only cdb_valid drops.
      for (int j = 0; j < CDB_WIDTH; j++) begin
        if (port_grant[j]) begin
          cdb_rob_id[j]   <= req_rob_id[port_src[j]];
          cdb_rd_phy[j]   <= req_rd_phy[port_src[j]];
          cdb_rd_arch[j]  <= req_rd_arch[port_src[j]];
          cdb_rd_value[j] <= req_rd_value[port_src[j]];
        end
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Randomized bench for cdb_arbiter, checked against a queue-based round-robin model,
// preceded by directed oversubscription, wrap, flush, reset and fairness scenarios.
module tb_cdb_arbiter;
  localparam int N = 3, W = 2, RB = 5, PB = 6, AB = 5;

  logic clk = 1'b0;
  logic rst, flush;
  logic [N-1:0]  req_valid, req_ready;
  logic [RB-1:0] req_rob_id   [N];
  logic [PB-1:0] req_rd_phy   [N];
  logic [AB-1:0] req_rd_arch  [N];
  logic [31:0]   req_rd_value [N];
  logic [W-1:0]  cdb_valid;
  logic [RB-1:0] cdb_rob_id   [W];
  logic [PB-1:0] cdb_rd_phy   [W];
  logic [AB-1:0] cdb_rd_arch  [W];
  logic [31:0]   cdb_rd_value [W];

  cdb_arbiter #(.N_REQ(N), .CDB_WIDTH(W), .ROB_IDX(RB), .PRF_IDX(PB), .ARF_IDX(AB)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_rob_id(req_rob_id), .req_rd_phy(req_rd_phy),
    .req_rd_arch(req_rd_arch), .req_rd_value(req_rd_value),
    .cdb_valid(cdb_valid), .cdb_rob_id(cdb_rob_id), .cdb_rd_phy(cdb_rd_phy),
    .cdb_rd_arch(cdb_rd_arch), .cdb_rd_value(cdb_rd_value)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: pointer, per-port valid and packed payload {rob, phy, arch, value}
  int          m_ptr;
  bit          m_cv  [W];
  logic [47:0] m_pay [W];
  logic [N-1:0] last_ready;
  bit          last_flush, last_rst;

  function automatic logic [47:0] req_pay(int i);
    return {req_rob_id[i], req_rd_phy[i], req_rd_arch[i], req_rd_value[i]};
  endfunction

  task automatic model_step(output logic [N-1:0] exp_ready);
    int order[$];
    exp_ready = '0;
    if (!rst && !flush)
      for (int k = 0; k < N; k++)
        if (req_valid[(m_ptr + k) % N]) order.push_back((m_ptr + k) % N);
    while (order.size() > W) void'(order.pop_back());
    foreach (order[g]) exp_ready[order[g]] = 1'b1;
    if (rst) begin
      m_ptr = 0;
      for (int j = 0; j < W; j++) begin m_cv[j] = 0; m_pay[j] = '0; end
    end else if (flush) begin
      m_ptr = 0;
      for (int j = 0; j < W; j++) m_cv[j] = 0;
    end else begin
      for (int j = 0; j < W; j++) begin
        m_cv[j] = (j < order.size());
        if (m_cv[j]) m_pay[j] = req_pay(order[j]);
      end
      if (order.size() > 0) m_ptr = (order[order.size()-1] + 1) % N;
    end
  endtask

  // Called with inputs settled at negedge; returns at the next negedge.
  task automatic step();
    logic [N-1:0] er;
    model_step(er);
    #1;
    check("req_ready", 64'(req_ready), 64'(er));
    last_ready = req_ready;
    last_flush = flush;
    last_rst   = rst;
    @(posedge clk);
    #1;
    for (int j = 0; j < W; j++) begin
      check($sformatf("cdb_valid[%0d]", j), 64'(cdb_valid[j]), 64'(m_cv[j]));
      check($sformatf("cdb_payload[%0d]", j),
            64'({cdb_rob_id[j], cdb_rd_phy[j], cdb_rd_arch[j], cdb_rd_value[j]}), 64'(m_pay[j]));
    end
    check("ptr", 64'(dut.ptr), 64'(m_ptr));
    @(negedge clk);
  endtask

  task automatic set_req(input int i, input bit v);
    req_valid[i]    = v;
    req_rob_id[i]   = RB'($urandom);
    req_rd_phy[i]   = PB'($urandom);
    req_rd_arch[i]  = AB'($urandom_range(0, 3) == 0 ? 0 : $urandom);
    req_rd_value[i] = $urandom;
  endtask

  // Protocol-respecting requesters: hold until accepted unless flushed or reset.
  task automatic update_reqs(input int pct);
    for (int i = 0; i < N; i++)
      if (!(req_valid[i] && !last_ready[i] && !last_flush && !last_rst))
        set_req(i, $urandom_range(0, 99) < pct);
  endtask

  int wait_cnt [N];
  int gcnt     [N];
  int max_wait;

  initial begin
    rst = 1'b1; flush = 1'b0; req_valid = '0;
    for (int i = 0; i < N; i++) set_req(i, 0);
    m_ptr = 0;
    for (int j = 0; j < W; j++) begin m_cv[j] = 0; m_pay[j] = '0; end
    @(negedge clk);
    step(); step();
    rst = 1'b0;

    // Single request from requester 1
    set_req(1, 1);
    req_rob_id[1] = 5'd3; req_rd_phy[1] = 6'd10; req_rd_value[1] = 32'hDEADBEEF;
    step();
    check("single_ready", 64'(last_ready), 64'(3'b010));
    check("single_cdb_valid", 64'(cdb_valid), 64'(2'b01));
    check("single_value", 64'(cdb_rd_value[0]), 64'(32'hDEADBEEF));
    check("single_ptr", 64'(dut.ptr), 64'd2);
    set_req(1, 0);

    // Oversubscription from ptr 0 (flush resets the pointer)
    flush = 1'b1; step(); flush = 1'b0;
    for (int i = 0; i < N; i++) set_req(i, 1);
    step();
    check("over_ptr0", 64'(dut.ptr), 64'd2);
    set_req(0, 1); set_req(1, 0);
    step();
    check("over_ready1", 64'(last_ready), 64'(3'b101));
    check("over_ptr1", 64'(dut.ptr), 64'd1);

    // Wrap: move ptr to 2, then reqs 0 and 2
    req_valid = '0; set_req(1, 1); step();
    set_req(1, 0); set_req(0, 1); set_req(2, 1);
    step();
    check("wrap_port0_rob", 64'(cdb_rob_id[0]), 64'(m_pay[0][47:43]));
    check("wrap_ptr", 64'(dut.ptr), 64'd1);

    // Flush with requests pending, after a cycle of live broadcasts
    set_req(0, 1); set_req(1, 1); step();
    set_req(0, 1); set_req(1, 1); flush = 1'b1;
    step();
    check("flush_ready", 64'(last_ready), 64'd0);
    check("flush_cdb_valid", 64'(cdb_valid), 64'd0);
    flush = 1'b0;

    // Reset the cycle after a 2-grant
    set_req(0, 1); set_req(1, 1); step();
    set_req(2, 1); rst = 1'b1;
    step();
    check("rst_ready", 64'(last_ready), 64'd0);
    check("rst_cdb_valid", 64'(cdb_valid), 64'd0);
    check("rst_value0", 64'(cdb_rd_value[0]), 64'd0);
    rst = 1'b0;

    // Fairness: all requesters always valid for 30 cycles from ptr 0
    rst = 1'b1; step(); rst = 1'b0;
    for (int i = 0; i < N; i++) begin set_req(i, 1); wait_cnt[i] = 0; gcnt[i] = 0; end
    max_wait = 0;
    for (int c = 0; c < 30; c++) begin
      step();
      for (int i = 0; i < N; i++) begin
        wait_cnt[i]++;
        if (last_ready[i]) begin
          gcnt[i]++;
          if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
          wait_cnt[i] = 0;
        end
      end
      update_reqs(100);
    end
    for (int i = 0; i < N; i++) check($sformatf("fair_grants[%0d]", i), 64'(gcnt[i]), 64'd20);
    check("fair_max_wait_le2", 64'(max_wait <= 2), 64'd1);

    // Random traffic with occasional flush and reset
    for (int c = 0; c < 2000; c++) begin
      update_reqs(60);
      flush = ($urandom_range(0, 99) < 3);
      rst   = ($urandom_range(0, 99) < 1);
      step();
    end
    rst = 1'b0; flush = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
